// File: rtl/pipe_latch_fifo_pkg.sv
// Shared pipeline types and per-boundary sizing for the elastic stage latches.
// Also holds a small helper used when checking buffer parameters.
package pipe_latch_fifo_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [7:0]  alu_op;
  } ie_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wr_en;
    logic [31:0] result;
  } ew_t;

  localparam int FD_W = $bits(fd_t);
  localparam int IE_W = $bits(ie_t);
  localparam int EW_W = $bits(ew_t);

  localparam int FD_DEPTH = 2;
  localparam int IE_DEPTH = 2;
  localparam int EW_DEPTH = 2;

  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/pipe_latch_fifo_chk.sv
// Parameter legality checks for pipe_latch_fifo; kept apart from the datapath.
module pipe_latch_fifo_chk
  import pipe_latch_fifo_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int AF_THRESH = 1
) (
  input logic CLK
);

  // Conditions are constant, so any violation is reported on the first edge.
  always_ff @(posedge CLK) begin
    assert (is_pow2(DEPTH) && (DEPTH >= 2))
      else $error("pipe_latch_fifo: DEPTH must be a power of two and >= 2");
    assert ((AF_THRESH >= 1) && (AF_THRESH <= DEPTH))
      else $error("pipe_latch_fifo: AF_THRESH must lie in 1..DEPTH");
  end

endmodule

// File: rtl/pipe_latch_fifo.sv
// Elastic valid/ready buffer between two pipeline stages, with flush and
// almost-full. No same-cycle bypass: ready never depends on out_ready.
module pipe_latch_fifo
  import pipe_latch_fifo_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 2,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_s;
  logic              pop_s;

  assign in_ready    = (count_r != CNT_FULL) && !flush;
  assign out_valid   = (count_r != {CNT_W{1'b0}}) && !flush;
  assign out_data    = mem_r[rd_ptr_r];
  assign count       = count_r;
  assign almost_full = (count_r >= CNT_AF);
  assign push_s      = in_valid && in_ready;
  assign pop_s       = out_valid && out_ready;

  // Pointer, count and storage update; flush leaves memory contents alone.
  always_ff @(posedge CLK) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  pipe_latch_fifo_chk #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_chk (
    .CLK (CLK)
  );

endmodule

// File: tb/tb_pipe_latch_fifo.sv
// Directed and randomized checks of pipe_latch_fifo (DEPTH=4) against a
// queue-based model of the buffer's occupancy and ordering rules.
module tb_pipe_latch_fifo;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int AF = 3;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [2:0]    count;
  logic          almost_full;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] model_q [$];

  always #5 CLK = ~CLK;

  pipe_latch_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic r, input logic f, input logic iv, input logic [DW-1:0] d,
                      input logic ordy, input bit en);
    bit exp_in_rdy, exp_out_vld, do_push, do_pop;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_in_rdy  = (model_q.size() != DP) && !f;
    exp_out_vld = (model_q.size() != 0) && !f;
    if (en) begin
      chk_val("count", 64'(count), 64'(model_q.size()));
      chk_val("in_ready", 64'(in_ready), 64'(exp_in_rdy));
      chk_val("out_valid", 64'(out_valid), 64'(exp_out_vld));
      chk_val("almost_full", 64'(almost_full), 64'(model_q.size() >= AF));
      if (exp_out_vld) chk_val("out_data", 64'(out_data), 64'(model_q[0]));
    end
    if (r || f) begin
      model_q.delete();
    end else begin
      do_push = iv && exp_in_rdy;
      do_pop  = ordy && exp_out_vld;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(negedge CLK);
  endtask

  initial begin
    bit hold_v;
    logic [DW-1:0] hold_d;
    logic r, f, iv, ordy;
    logic [DW-1:0] d;

    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_val("reset_out_data", 64'(out_data), 64'h0);
    chk_val("reset_count", 64'(count), 64'h0);

    // Fill and drain
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'hA1 + 8'(i), 1'b0, 1'b1);
    chk_val("fill_count", 64'(count), 64'd4);
    chk_val("fill_in_ready", 64'(in_ready), 64'd0);
    step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1 chk_val("drain_data", 64'(out_data), 64'(8'hA1 + 8'(i)));
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    end
    chk_val("drained_valid", 64'(out_valid), 64'd0);

    // Wrap-around at count=1
    step(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'h11 + 8'(i), 1'b1, 1'b1);
    chk_val("wrap_count", 64'(count), 64'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Full with simultaneous push attempt and pop: 4 -> 3 -> 4
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'hB1 + 8'(i), 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b1);
    chk_val("full_pop_count", 64'(count), 64'd3);
    step(1'b0, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b1);
    chk_val("full_repush_count", 64'(count), 64'd4);

    // Flush at count=3 with a simultaneous payload
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    chk_val("flush_count", 64'(count), 64'd0);
    chk_val("flush_valid", 64'(out_valid), 64'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Reset mid-stream with a simultaneous push
    step(1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h23, 1'b0, 1'b1);
    chk_val("rst_mid_count", 64'(count), 64'd0);
    step(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    chk_val("post_rst_data", 64'(out_data), 64'h55);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Randomized traffic; upstream holds its payload while stalled
    hold_v = 1'b0;
    hold_d = 8'h00;
    for (int c = 0; c < 600; c++) begin
      r    = ($urandom_range(0, 59) == 0);
      f    = ($urandom_range(0, 24) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      if (hold_v) begin
        iv = 1'b1;
        d  = hold_d;
      end else begin
        iv = ($urandom_range(0, 2) != 0);
        d  = 8'($urandom);
      end
      hold_v = iv && !r && ((model_q.size() == DP) || f);
      hold_d = d;
      step(r, f, iv, d, ordy, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
